mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
- MEM-stage load/store engine. It consumes the EX/MEM pipeline register outputs (destination register, ALU address, store data) plus a memory-op code.
- Runs one transaction per instruction on a word-wide req/ack data-memory bus, with byte-lane steering for stores and lane extraction plus sign/zero extension for loads.
- Stalls the pipeline until the access completes, faults or times out, then presents a one-cycle result toward MEM/WB.

Parameters:
- WordSize, 32, data/address width; only 32 supported (4 byte lanes).
- TimeoutCycles, 255, max cycles waiting for bus_ack before fault; range 1..255.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- op_valid  input  1  memory op present from EX/MEM
- mem_op  input  4  [3]=store, [2]=unsigned load, [1:0]=size (00 byte, 01 half, 10 word, 11 illegal)
- rdn  input  5  load destination register
- alu_out  input  WordSize  byte address
- mem_data  input  WordSize  store data (value in low bits)
- bus_req  output  1  bus request
- bus_we  output  1  1=write
- bus_addr  output  WordSize  word-aligned address ({alu_out[31:2],2'b00})
- bus_wdata  output  WordSize  lane-replicated store data
- bus_wstrb  output  4  byte enables
- bus_rdata  input  WordSize  read data, valid on bus_ack
- bus_ack  input  1  bus completion
- stall  output  1  hold upstream pipeline
- done  output  1  one-cycle result strobe
- rd_out  output  5  writeback register (0 for stores and faults)
- rd_data  output  WordSize  extended load result (0 for stores and faults)
- fault  output  1  misaligned, illegal size or timeout; valid with done

Behaviour:
- Reset: state IDLE; bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb, done, rd_out, rd_data, fault and the timeout counter all 0.
- FSM states: IDLE, REQ, RESP.
- IDLE, op_valid=1:
  - Latch mem_op, rdn and alu_out; compute wdata/wstrb.
  - Legal and aligned: go to REQ.
  - Illegal or misaligned: go to RESP with fault=1 and no bus request.
  - Misaligned means half with addr[0]=1, or word with addr[1:0]!=0. Size 11 is illegal.
- IDLE, op_valid=0: stay in IDLE.
- REQ:
  - bus_req=1; bus_we, bus_addr, bus_wdata and bus_wstrb held stable.
  - Timeout counter increments each REQ cycle without ack.
  - bus_ack=1: capture bus_rdata, go to RESP.
  - Counter reaches TimeoutCycles with no ack: go to RESP with fault=1.
  - Ack and timeout in the same cycle: ack wins, no fault.
- RESP:
  - done=1 for exactly one cycle; then go to IDLE and clear the counter.
  - bus_req=0.
- stall = op_valid & (state != RESP), combinational. Upstream advances in the RESP cycle; the next op is sampled in the following IDLE cycle.
- Minimum latency: 2 cycles from op_valid to done (ack in the first REQ cycle). Fault path latency is 1 cycle (IDLE to RESP).
- Store steering, with lane offset o = alu_out[1:0]:
  - byte: wdata = {4{mem_data[7:0]}}, wstrb = 0001<<o
  - half: wdata = {2{mem_data[15:0]}}, wstrb = 0011<<o
  - word: wdata = mem_data, wstrb = 1111
- Load extraction: shift bus_rdata right by 8*o, then sign-extend from the op size, or zero-extend when mem_op[2]=1. The result is registered into rd_data in RESP.
- Loads: rd_out = latched rdn. Stores: rd_out = 0, rd_data = 0.
- Register outputs: done, rd_out, rd_data and fault are registered and are 0 outside RESP.
- Input changes and mid-transaction behaviour:
  - Changes on op_valid, mem_op, rdn, alu_out or mem_data after leaving IDLE are ignored.
  - Dropping op_valid mid-REQ does not abort the transaction.
- bus_ack while not in REQ: ignored.
- rst asserted in any state:
  - Next edge returns to IDLE, drops bus_req and clears the counter.
  - No done is produced for the aborted op.

Test Plan:
- Word load, alu_out=0x100, bus_rdata=0xDEADBEEF, ack in first REQ cycle -> bus_addr=0x100, bus_we=0; done 2 cycles after op_valid with rd_data=0xDEADBEEF, rd_out=rdn; stall high for 2 cycles.
- Signed byte load, alu_out=0x103, rdata=0x80000000 -> rd_data=0xFFFFFF80. Repeat with mem_op[2]=1 -> rd_data=0x00000080.
- Half store, alu_out=0x202, mem_data=0x1234ABCD -> bus_wdata=0xABCDABCD, bus_wstrb=1100, bus_we=1, bus_addr=0x200. Ack after 3 wait cycles -> bus_req held 4 cycles; done with rd_out=0.
- Misaligned word load, alu_out=0x101 -> no bus_req; done with fault=1, rd_out=0, one cycle after op_valid.
- Timeout with TimeoutCycles=4, no ack -> bus_req high 4 cycles, then done with fault=1. Ack on the 4th cycle -> fault=0.
- rst pulsed during REQ -> bus_req=0 the next cycle, no done. Subsequent word load completes normally.

Source files
------------

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//   MEM-stage load/store engine. Takes the EX/MEM register outputs (destination
//   register, byte address, store data) and a memory-op code, runs one
//   req/ack transaction on a word-wide data bus, and returns a one-cycle result
//   strobe toward MEM/WB. Stores are lane-replicated with byte strobes; loads
//   are lane-extracted and sign- or zero-extended.
//
// Ports
//   clk, rst         clock, synchronous active-high reset
//   op_valid         memory op present from EX/MEM
//   mem_op[3:0]      [3]=store, [2]=unsigned load, [1:0]=size (00 b, 01 h, 10 w)
//   rdn              load destination register
//   alu_out          byte address
//   mem_data         store data (value in low bits)
//   bus_req/bus_we   bus request / write enable
//   bus_addr         word-aligned address
//   bus_wdata/wstrb  lane-replicated store data and byte enables
//   bus_rdata/ack    read data (valid with ack) / completion
//   stall            hold upstream pipeline (combinational)
//   done             one-cycle result strobe
//   rd_out/rd_data   writeback register and extended load data (0 on store/fault)
//   fault            misaligned, illegal size or timeout; valid with done
//   dbg_state        current FSM state (0 IDLE, 1 REQ, 2 RESP)
//
// Handshake: bus_req rises on the cycle after the op is accepted and stays high,
// with bus_we/addr/wdata/wstrb stable, until the first cycle bus_ack is seen
// high; that cycle completes the transfer and bus_req drops on the next edge.
// bus_ack outside a request is ignored.
// -----------------------------------------------------------------------------
module mem_access_unit #(
  parameter int WordSize      = 32,
  parameter int TimeoutCycles = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                op_valid,
  input  logic [3:0]          mem_op,
  input  logic [4:0]          rdn,
  input  logic [WordSize-1:0] alu_out,
  input  logic [WordSize-1:0] mem_data,
  output logic                bus_req,
  output logic                bus_we,
  output logic [WordSize-1:0] bus_addr,
  output logic [WordSize-1:0] bus_wdata,
  output logic [3:0]          bus_wstrb,
  input  logic [WordSize-1:0] bus_rdata,
  input  logic                bus_ack,
  output logic                stall,
  output logic                done,
  output logic [4:0]          rd_out,
  output logic [WordSize-1:0] rd_data,
  output logic                fault,
  output logic [1:0]          dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [7:0] TimeoutLimit = 8'(TimeoutCycles);

  state_t              r_state;
  logic [3:0]          r_op;
  logic [4:0]          r_rdn;
  logic [1:0]          r_off;
  logic [7:0]          r_cnt;

  logic [1:0]          w_size;
  logic [1:0]          w_off;
  logic                w_bad;
  logic [WordSize-1:0] w_wdata;
  logic [3:0]          w_wstrb;
  logic [WordSize-1:0] w_shift;
  logic [WordSize-1:0] w_load;
  logic                w_timeout;

  assign w_size = mem_op[1:0];
  assign w_off  = alu_out[1:0];

  // Size 11 is illegal; halves need an even offset, words a zero offset.
  assign w_bad = (w_size == 2'b11) ||
                 ((w_size == 2'b01) && w_off[0]) ||
                 ((w_size == 2'b10) && (w_off != 2'b00));

  // Store lane steering: replicate the value across lanes, strobe the target.
  always_comb begin
    w_wdata = mem_data;
    w_wstrb = 4'b0000;
    case (w_size)
      2'b00: begin
        w_wdata = {4{mem_data[7:0]}};
        w_wstrb = 4'b0001 << w_off;
      end
      2'b01: begin
        w_wdata = {2{mem_data[15:0]}};
        w_wstrb = 4'b0011 << w_off;
      end
      2'b10: begin
        w_wdata = mem_data;
        w_wstrb = 4'b1111;
      end
      default: begin
        w_wdata = mem_data;
        w_wstrb = 4'b0000;
      end
    endcase
    if (!mem_op[3]) w_wstrb = 4'b0000;
  end

  // Load extraction uses the offset/op latched at accept time.
  assign w_shift = bus_rdata >> {r_off, 3'b000};

  always_comb begin
    w_load = bus_rdata;
    case (r_op[1:0])
      2'b00: w_load = r_op[2] ? {{(WordSize-8){1'b0}}, w_shift[7:0]}
                              : {{(WordSize-8){w_shift[7]}}, w_shift[7:0]};
      2'b01: w_load = r_op[2] ? {{(WordSize-16){1'b0}}, w_shift[15:0]}
                              : {{(WordSize-16){w_shift[15]}}, w_shift[15:0]};
      default: w_load = bus_rdata;
    endcase
  end

  // Fires on the REQ cycle in which the count would reach the limit.
  assign w_timeout = ((r_cnt + 8'd1) == TimeoutLimit);

  assign stall     = op_valid && (r_state != S_RESP);
  assign dbg_state = r_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_op      <= 4'b0000;
      r_rdn     <= 5'd0;
      r_off     <= 2'b00;
      r_cnt     <= 8'd0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_wstrb <= 4'b0000;
      done      <= 1'b0;
      rd_out    <= 5'd0;
      rd_data   <= '0;
      fault     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          done    <= 1'b0;
          fault   <= 1'b0;
          rd_out  <= 5'd0;
          rd_data <= '0;
          r_cnt   <= 8'd0;
          if (op_valid) begin
            r_op      <= mem_op;
            r_rdn     <= rdn;
            r_off     <= w_off;
            bus_addr  <= {alu_out[WordSize-1:2], 2'b00};
            bus_wdata <= w_wdata;
            bus_wstrb <= w_wstrb;
            if (w_bad) begin
              // Fault without touching the bus.
              bus_we  <= 1'b0;
              r_state <= S_RESP;
              done    <= 1'b1;
              fault   <= 1'b1;
            end else begin
              bus_we  <= mem_op[3];
              bus_req <= 1'b1;
              r_state <= S_REQ;
            end
          end
        end

        S_REQ: begin
          if (bus_ack) begin
            // Ack beats a coincident timeout.
            bus_req <= 1'b0;
            r_state <= S_RESP;
            done    <= 1'b1;
            fault   <= 1'b0;
            if (!r_op[3]) begin
              rd_out  <= r_rdn;
              rd_data <= w_load;
            end
          end else if (w_timeout) begin
            bus_req <= 1'b0;
            r_state <= S_RESP;
            done    <= 1'b1;
            fault   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end

        S_RESP: begin
          done    <= 1'b0;
          fault   <= 1'b0;
          rd_out  <= 5'd0;
          rd_data <= '0;
          r_cnt   <= 8'd0;
          bus_req <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          bus_req <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
